// File: rtl/string_display_engine_if.sv
// string_display_engine_if: text buffer write port, VGA position inputs and glyph pixel outputs
interface string_display_engine_if #(
  parameter int CNT_WIDTH  = 10,
  parameter int ADDR_WIDTH = 17,
  parameter int MAX_CHARS  = 16,
  parameter int CODE_WIDTH = 5
);
  localparam int IDX_W = $clog2(MAX_CHARS);
  logic [CNT_WIDTH-1:0]  h_cnt;
  logic [CNT_WIDTH-1:0]  v_cnt;
  logic [CNT_WIDTH-1:0]  h_start;
  logic [CNT_WIDTH-1:0]  v_start;
  logic                  frame_start;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [CODE_WIDTH-1:0] wr_code;
  logic [IDX_W:0]        wr_len;
  logic                  commit;
  logic                  scroll_en;
  logic                  commit_pend;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  logic                  pixel_valid;
  modport master (
    output h_cnt, v_cnt, h_start, v_start, frame_start, wr_en, wr_idx, wr_code, wr_len, commit, scroll_en,
    input  commit_pend, pixel_addr, pixel_valid
  );
  modport slave (
    input  h_cnt, v_cnt, h_start, v_start, frame_start, wr_en, wr_idx, wr_code, wr_len, commit, scroll_en,
    output commit_pend, pixel_addr, pixel_valid
  );
endinterface

// File: rtl/string_display_engine.sv
// string_display_engine: double-buffered text renderer producing glyph ROM addresses, optional marquee via STRING_SCROLL_EN
module string_display_engine #(
  parameter int CNT_WIDTH    = 10,
  parameter int ADDR_WIDTH   = 17,
  parameter int IMAGE_WIDTH  = 405,
  parameter int IMAGE_HEIGHT = 30,
  parameter int CHAR_W       = 15,
  parameter int MAX_CHARS    = 16,
  parameter int CODE_WIDTH   = 5,
  parameter int SCALE_SHIFT  = 0
) (
  input logic clk,
  input logic rst,
  string_display_engine_if.slave bus
);
  localparam int IDX_W      = $clog2(MAX_CHARS);
  localparam int NUM_GLYPHS = IMAGE_WIDTH / CHAR_W;
  localparam int CHAR_H     = IMAGE_HEIGHT;
  localparam int SW         = $clog2(MAX_CHARS * CHAR_W + 1);
  localparam int HW         = (CNT_WIDTH > SW ? CNT_WIDTH : SW) + 1;
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_n;
  logic [CODE_WIDTH-1:0] shadow [MAX_CHARS];
  logic [CODE_WIDTH-1:0] active [MAX_CHARS];
  logic [IDX_W:0] shadow_len, act_len, len_n, len_clamp;
  logic swap;
  logic [HW-1:0] span, offset, rel_h, sum, rel_hp, h1;
  logic [CNT_WIDTH-1:0] dh, dv, rel_v, r1;
  logic in_box, v1;
  logic [IDX_W-1:0] idx;
  logic [CODE_WIDTH-1:0] code;
  logic [ADDR_WIDTH-1:0] col, addr;
  logic ok;
  // buffer FSM: commit arms a swap, the next frame_start performs it; commit always re-latches the length
  always_comb begin
    len_clamp = 32'(bus.wr_len) > MAX_CHARS ? (IDX_W+1)'(MAX_CHARS) : bus.wr_len;
    len_n     = bus.commit ? len_clamp : shadow_len;
    swap      = state == PEND && bus.frame_start;
    state_n   = state == IDLE ? (bus.commit ? PEND : IDLE) : (bus.frame_start ? IDLE : PEND);
  end
  // FSM state and shadow length register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow_len <= '0;
    end else begin
      state      <= state_n;
      shadow_len <= len_n;
    end
  end
  assign bus.commit_pend = state == PEND;
  // shadow takes writes; active copies the pre-write shadow on swap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      act_len <= '0;
    end else begin
      if (bus.wr_en && 32'(bus.wr_idx) < MAX_CHARS) shadow[bus.wr_idx] <= bus.wr_code;
      if (swap) begin
        for (int i = 0; i < MAX_CHARS; i++) active[i] <= shadow[i];
        act_len <= shadow_len;
      end
    end
  end
  assign span = HW'(act_len) * HW'(CHAR_W);
`ifdef STRING_SCROLL_EN
  // marquee offset steps once per frame, wraps at the string width, restarts on every swap
  always_ff @(posedge clk) begin
    if (rst || swap) offset <= '0;
    else if (bus.frame_start && bus.scroll_en) offset <= (span == '0 || offset >= span - 1'b1) ? '0 : offset + 1'b1;
  end
`else
  assign offset = '0;
`endif
  // stage 1 math: unsigned offsets from the string origin, box test guards the wrapped subtraction
  always_comb begin
    dh     = bus.h_cnt - bus.h_start;
    dv     = bus.v_cnt - bus.v_start;
    rel_h  = HW'(dh >> SCALE_SHIFT);
    rel_v  = dv >> SCALE_SHIFT;
    sum    = rel_h + offset;
    rel_hp = sum >= span ? sum - span : sum;
    in_box = bus.h_cnt >= bus.h_start && bus.v_cnt >= bus.v_start && rel_h < span && 32'(rel_v) < CHAR_H;
  end
  // stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      h1 <= '0;
      r1 <= '0;
    end else begin
      v1 <= in_box;
      h1 <= rel_hp;
      r1 <= rel_v;
    end
  end
  // stage 2 math: slot lookup and sheet address; codes past the sheet are blanked
  always_comb begin
    idx  = IDX_W'(h1 / HW'(CHAR_W));
    col  = ADDR_WIDTH'(h1 % HW'(CHAR_W));
    code = active[idx];
    ok   = v1 && 32'(code) < NUM_GLYPHS;
    addr = ADDR_WIDTH'(code) * ADDR_WIDTH'(CHAR_W) + col + ADDR_WIDTH'(IMAGE_WIDTH) * ADDR_WIDTH'(r1);
  end
  // stage 2 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pixel_valid <= 1'b0;
      bus.pixel_addr  <= '0;
    end else begin
      bus.pixel_valid <= ok;
      bus.pixel_addr  <= ok ? addr : '0;
    end
  end
endmodule
